johnson_phase_monitor: RTL and testbench

//  Downstream consumer of the N-bit Johnson counter. Decodes its code to a binary phase and a one-hot strobe.

---
 rtl/johnson_phase_monitor.sv | 185 ++++++++++++++++++
 tb/tb_johnson_phase_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: decodes phase/one-hot, checks code legality and succession,
// tracks lock with a small FSM, counts lock-time errors and flags full revolutions.
module johnson_phase_monitor #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [N-1:0]                jc_in,
  input  logic                        clr_err,
  output logic [$clog2(2*N)-1:0]      phase,
  output logic [2*N-1:0]              phase_oh,
  output logic                        valid,
  output logic                        locked,
  output logic                        err_pulse,
  output logic [ERR_W-1:0]            err_cnt,
  output logic                        wrap_pulse
);

  localparam int unsigned NP = 2 * N;
  localparam int unsigned PW = $clog2(NP);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StUnlock, StAcq, StLock} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     good_q, good_d;
  logic [PW-1:0]     phase_q;
  logic [NP-1:0]     phase_oh_q;
  logic              valid_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic              wrap_q;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  // Code for phase k: top k bits set for k <= N, low 2N-k bits set beyond that.
  function automatic logic [N-1:0] code_of(input int unsigned k);
    logic [N-1:0] ones;
    ones = '1;
    if (k <= N) begin
      code_of = ~(ones >> k);
    end else begin
      code_of = ones >> (k - N);
    end
  endfunction

  logic [NP-1:0] hit;
  logic          legal;
  logic [PW-1:0] p;

  always_comb begin
    hit   = '0;
    p     = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      hit[k] = (jc_in == code_of(k));
    end
    legal = |hit;
    for (int unsigned k = 0; k < NP; k++) begin
      if (hit[k]) begin
        p = PW'(k);
      end
    end
  end

  // phase_q doubles as the last legal phase; it only moves on legal samples.
  logic [PW-1:0] last_phase;
  logic [PW-1:0] succ_phase;
  logic          at_last;
  logic          is_succ;
  logic          is_restart;

  always_comb begin
    last_phase = PW'(NP - 1);
    at_last    = (phase_q == last_phase);
    succ_phase = at_last ? '0 : phase_q + 1'b1;
    is_succ    = legal && (p == succ_phase);
    is_restart = legal && (p == '0) && !at_last;
  end

  logic err_evt;
  logic wrap_d;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_evt = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      case (state_q)
        StUnlock: begin
          if (legal) begin
            state_d = StAcq;
            good_d  = '0;
          end
        end
        StAcq: begin
          if (!legal) begin
            state_d = StUnlock;
            good_d  = '0;
          end else if (is_succ) begin
            if (good_q == GW'(LOCK_CNT - 1)) begin
              state_d = StLock;
              good_d  = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        StLock: begin
          if (!legal) begin
            err_evt = 1'b1;
            state_d = StUnlock;
            good_d  = '0;
          end else if (is_succ) begin
            wrap_d = at_last;
          end else if (is_restart) begin
            // A counter restart is expected behaviour, so it re-acquires without an error.
            state_d = StAcq;
            good_d  = '0;
          end else begin
            err_evt = 1'b1;
            state_d = StAcq;
            good_d  = '0;
          end
        end
        default: begin
          state_d = StUnlock;
          good_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (err_evt && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StUnlock;
      good_q      <= '0;
      phase_q     <= '0;
      phase_oh_q  <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      locked_q    <= (state_d == StLock);
      err_pulse_q <= err_evt;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
      if (en) begin
        valid_q <= legal;
        if (legal) begin
          phase_q    <= p;
          phase_oh_q <= NP'(1) << p;
        end else begin
          phase_oh_q <= '0;
        end
      end
    end
  end

  assign phase      = phase_q;
  assign phase_oh   = phase_oh_q;
  assign valid      = valid_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor (N=4, LOCK_CNT=4, ERR_W=2) with an expectation queue.
module tb_johnson_phase_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] jc_in;
  logic       clr_err;
  logic [2:0] phase;
  logic [7:0] phase_oh;
  logic       valid;
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_cnt;
  logic       wrap_pulse;

  johnson_phase_monitor #(
    .N        (4),
    .LOCK_CNT (4),
    .ERR_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .jc_in      (jc_in),
    .clr_err    (clr_err),
    .phase      (phase),
    .phase_oh   (phase_oh),
    .valid      (valid),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] oh;
    logic       v;
    logic       lk;
    logic       ep;
    logic [1:0] ec;
    logic       wp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_n   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".phase"},    32'(phase),      32'd0);
    check({tag, ".phase_oh"}, 32'(phase_oh),   32'd0);
    check({tag, ".valid"},    32'(valid),      32'd0);
    check({tag, ".locked"},   32'(locked),     32'd0);
    check({tag, ".err_pulse"},32'(err_pulse),  32'd0);
    check({tag, ".err_cnt"},  32'(err_cnt),    32'd0);
    check({tag, ".wrap"},     32'(wrap_pulse), 32'd0);
  endtask

  // Drive one sample and the outputs expected after the edge that takes it.
  task automatic step(input int e, input logic [3:0] jc, input int c, input int ph, input int v,
                      input int lk, input int ep, input int ec, input int wp);
    exp_t x;
    x.ph = 3'(ph);
    x.v  = (v != 0);
    x.oh = (v != 0) ? (8'h01 << ph) : 8'h00;
    x.lk = (lk != 0);
    x.ep = (ep != 0);
    x.ec = 2'(ec);
    x.wp = (wp != 0);
    sb.push_back(x);
    @(negedge clk);
    en      = (e != 0);
    jc_in   = jc;
    clr_err = (c != 0);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    step_n++;
    check($sformatf("s%0d.phase", step_n),     32'(phase),      32'(x.ph));
    check($sformatf("s%0d.phase_oh", step_n),  32'(phase_oh),   32'(x.oh));
    check($sformatf("s%0d.valid", step_n),     32'(valid),      32'(x.v));
    check($sformatf("s%0d.locked", step_n),    32'(locked),     32'(x.lk));
    check($sformatf("s%0d.err_pulse", step_n), 32'(err_pulse),  32'(x.ep));
    check($sformatf("s%0d.err_cnt", step_n),   32'(err_cnt),    32'(x.ec));
    check($sformatf("s%0d.wrap", step_n),      32'(wrap_pulse), 32'(x.wp));
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    jc_in   = 4'b0000;
    clr_err = 1'b0;
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Acquire and lock from phase 0
    //   en  jc       clr ph v lk ep ec wp
    step(1, 4'b0000, 0,  0, 1, 0, 0, 0, 0);
    step(1, 4'b1000, 0,  1, 1, 0, 0, 0, 0);
    step(1, 4'b1100, 0,  2, 1, 0, 0, 0, 0);
    step(1, 4'b1110, 0,  3, 1, 0, 0, 0, 0);
    step(1, 4'b1111, 0,  4, 1, 1, 0, 0, 0);
    // Revolution wrap
    step(1, 4'b0111, 0,  5, 1, 1, 0, 0, 0);
    step(1, 4'b0011, 0,  6, 1, 1, 0, 0, 0);
    step(1, 4'b0001, 0,  7, 1, 1, 0, 0, 0);
    step(1, 4'b0000, 0,  0, 1, 1, 0, 0, 1);
    step(1, 4'b1000, 0,  1, 1, 1, 0, 0, 0);
    step(1, 4'b1100, 0,  2, 1, 1, 0, 0, 0);
    // Illegal code while locked
    step(1, 4'b1010, 0,  2, 0, 0, 1, 1, 0);
    step(1, 4'b1010, 0,  2, 0, 0, 0, 1, 0);
    step(1, 4'b0000, 0,  0, 1, 0, 0, 1, 0);
    step(1, 4'b1000, 0,  1, 1, 0, 0, 1, 0);
    step(1, 4'b1100, 0,  2, 1, 0, 0, 1, 0);
    step(1, 4'b1110, 0,  3, 1, 0, 0, 1, 0);
    step(1, 4'b1111, 0,  4, 1, 1, 0, 1, 0);
    step(1, 4'b0111, 0,  5, 1, 1, 0, 1, 0);
    step(1, 4'b0011, 0,  6, 1, 1, 0, 1, 0);
    step(1, 4'b0001, 0,  7, 1, 1, 0, 1, 0);
    step(1, 4'b0000, 0,  0, 1, 1, 0, 1, 1);
    step(1, 4'b1000, 0,  1, 1, 1, 0, 1, 0);
    step(1, 4'b1100, 0,  2, 1, 1, 0, 1, 0);
    // Skip 2 -> 4 while locked, then 4 successors relock (no wrap outside LOCK)
    step(1, 4'b1111, 0,  4, 1, 0, 1, 2, 0);
    step(1, 4'b0111, 0,  5, 1, 0, 0, 2, 0);
    step(1, 4'b0011, 0,  6, 1, 0, 0, 2, 0);
    step(1, 4'b0001, 0,  7, 1, 0, 0, 2, 0);
    step(1, 4'b0000, 0,  0, 1, 1, 0, 2, 0);
    // Restart from phase 3: unlock without error
    step(1, 4'b1000, 0,  1, 1, 1, 0, 2, 0);
    step(1, 4'b1100, 0,  2, 1, 1, 0, 2, 0);
    step(1, 4'b1110, 0,  3, 1, 1, 0, 2, 0);
    step(1, 4'b0000, 0,  0, 1, 0, 0, 2, 0);
    step(1, 4'b1000, 0,  1, 1, 0, 0, 2, 0);
    // en=0 freezes everything
    step(0, 4'b1100, 0,  1, 1, 0, 0, 2, 0);
    step(0, 4'b1010, 0,  1, 1, 0, 0, 2, 0);
    step(1, 4'b1100, 0,  2, 1, 0, 0, 2, 0);
    step(1, 4'b1110, 0,  3, 1, 0, 0, 2, 0);
    step(1, 4'b1111, 0,  4, 1, 1, 0, 2, 0);
    step(1, 4'b0111, 0,  5, 1, 1, 0, 2, 0);
    step(1, 4'b0011, 0,  6, 1, 1, 0, 2, 0);
    step(1, 4'b0001, 0,  7, 1, 1, 0, 2, 0);
    step(0, 4'b0000, 0,  7, 1, 1, 0, 2, 0);
    step(0, 4'b1010, 0,  7, 1, 1, 0, 2, 0);
    step(1, 4'b0000, 0,  0, 1, 1, 0, 2, 1);
    // Saturation at 3
    step(1, 4'b1010, 0,  0, 0, 0, 1, 3, 0);
    step(1, 4'b0000, 0,  0, 1, 0, 0, 3, 0);
    step(1, 4'b1000, 0,  1, 1, 0, 0, 3, 0);
    step(1, 4'b1100, 0,  2, 1, 0, 0, 3, 0);
    step(1, 4'b1110, 0,  3, 1, 0, 0, 3, 0);
    step(1, 4'b1111, 0,  4, 1, 1, 0, 3, 0);
    step(1, 4'b1111, 0,  4, 1, 0, 1, 3, 0);
    step(1, 4'b0111, 0,  5, 1, 0, 0, 3, 0);
    step(1, 4'b0011, 0,  6, 1, 0, 0, 3, 0);
    step(1, 4'b0001, 0,  7, 1, 0, 0, 3, 0);
    step(1, 4'b0000, 0,  0, 1, 1, 0, 3, 0);
    // clr_err wins over a coincident error
    step(1, 4'b1111, 1,  4, 1, 0, 1, 0, 0);
    step(1, 4'b0111, 0,  5, 1, 0, 0, 0, 0);
    step(1, 4'b0011, 0,  6, 1, 0, 0, 0, 0);
    step(1, 4'b0001, 0,  7, 1, 0, 0, 0, 0);
    step(1, 4'b0000, 0,  0, 1, 1, 0, 0, 0);
    step(1, 4'b1010, 0,  0, 0, 0, 1, 1, 0);
    // clr_err acts while en=0
    step(0, 4'b0000, 1,  0, 0, 0, 0, 0, 0);
    step(1, 4'b0000, 0,  0, 1, 0, 0, 0, 0);
    step(1, 4'b1000, 0,  1, 1, 0, 0, 0, 0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    // First legal sample after reset is unclassified
    step(1, 4'b1000, 0,  1, 1, 0, 0, 0, 0);
    step(1, 4'b1100, 0,  2, 1, 0, 0, 0, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
